// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the watch-face 7-segment scanner:
//   - segment patterns {g,f,e,d,c,b,a}, active-high, for digits 0-9,
//     the dash shown for non-BCD values, and the all-off pattern
//   - AN_OFF, the active-low digit-enable value with every digit dark
//   - digit_idx_t, the 2-bit scan slot index (0 = min0 ... 3 = hour1)
//   - an_select(), which maps a slot index to its one-hot-low enable
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // One-hot-low digit enable for the given slot.
    function automatic logic [3:0] an_select(input digit_idx_t idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd2seg.sv
// -----------------------------------------------------------------------------
// bcd2seg
// Purely combinational BCD to 7-segment decoder. Values 10-15 are not valid
// BCD and are shown as a dash so a corrupted counter is visible on the face.
//   digit  in  4  BCD value
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module bcd2seg
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Four-digit multiplexed 7-segment scanner for the hh:mm watch face. Each
// digit owns a slot of PRESCALE cycles; the first DEAD cycles of every slot
// are blanked to stop ghosting between digits. The four input digits are
// copied into a shadow register once per frame, at the very end of slot 3,
// so one frame never shows a mix of old and new time. The colon toggles on
// every second tick, independently of the scan.
//
// Parameters:
//   PRESCALE  clock cycles per digit slot (>= 4)
//   DEAD      blanked cycles at the start of each slot (1 <= DEAD < PRESCALE)
//
// Ports:
//   clk_i       in   1  system clock
//   rst_ni      in   1  asynchronous active-low reset
//   min0_i      in   4  BCD minute units
//   min1_i      in   4  BCD minute tens
//   hour0_i     in   4  BCD hour units
//   hour1_i     in   4  BCD hour tens
//   sec_tick_i  in   1  one-cycle pulse per second
//   seg_o       out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//   an_o        out  4  digit enables, active-low one-hot, registered
//                       (bit0 = min0 ... bit3 = hour1)
//   colon_o     out  1  colon LEDs, active-high, registered
//
// Build option:
//   SEG7_LZB_EN  when defined, a zero hour-tens digit is blanked for its
//                whole slot (leading-zero blanking); slot timing is unchanged.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int DEAD     = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] min0_i,
    input  logic [3:0] min1_i,
    input  logic [3:0] hour0_i,
    input  logic [3:0] hour1_i,
    input  logic       sec_tick_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       colon_o
);

    localparam int                CNT_W    = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD);

    if (PRESCALE < 4) begin : g_bad_prescale
        $error("seg7_scan_driver: PRESCALE must be at least 4");
    end
    if (DEAD < 1 || DEAD >= PRESCALE) begin : g_bad_dead
        $error("seg7_scan_driver: DEAD must satisfy 1 <= DEAD < PRESCALE");
    end

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    logic [3:0][3:0]  shadow;      // [0]=min0 [1]=min1 [2]=hour0 [3]=hour1
    logic             slot_end;
    logic             frame_end;
    logic [6:0]       seg_dec;
    logic             lzb_blank;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    // Slot prescaler and digit index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow copy of the time, refreshed only between frames.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the shadow is reset because the first frame after reset must show a defined "0".
            shadow <= '0;
        end else if (frame_end) begin
            shadow <= {hour1_i, hour0_i, min1_i, min0_i};
        end
    end

    bcd2seg u_bcd2seg (
        .digit (shadow[idx]),
        .seg   (seg_dec)
    );

`ifdef SEG7_LZB_EN
    assign lzb_blank = (idx == 2'd3) && (shadow[3] == 4'd0);
`else
    assign lzb_blank = 1'b0;
`endif

    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = AN_OFF;
        if (cnt >= CNT_DEAD && !lzb_blank) begin
            seg_next = seg_dec;
            an_next  = an_select(idx);
        end
    end

    // Registered pad drivers; the colon is a plain toggle on the second tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_o   <= SEG_BLANK;
            an_o    <= AN_OFF;
            colon_o <= 1'b0;
        end else begin
            seg_o   <= seg_next;
            an_o    <= an_next;
            colon_o <= colon_o ^ sec_tick_i;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with PRESCALE = 8, DEAD = 2.
// k counts rising edges since reset release; outputs are sampled 1 time unit
// after edge k and then reflect the scan position (k-1): slot = ((k-1)/8)%4,
// position in slot = (k-1)%8, frame = (k-1)/32. The shadow used by frame f
// (f >= 1) holds the inputs present at edge 32*f.
// Define SEG7_LZB_EN for both bench and RTL to check leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [3:0] min0, min1, hour0, hour1;
    logic       sec_tick;
    logic [6:0] seg;
    logic [3:0] an;
    logic       colon;

    int n_checks = 0;
    int n_passed = 0;
    int k        = 0;

    seg7_scan_driver #(
        .PRESCALE (8),
        .DEAD     (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .min0_i     (min0),
        .min1_i     (min1),
        .hour0_i    (hour0),
        .hour1_i    (hour1),
        .sec_tick_i (sec_tick),
        .seg_o      (seg),
        .an_o       (an),
        .colon_o    (colon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%02h, expected 0x%02h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Advance to rising edge number target and settle just past it.
    task automatic go(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        check({tag, ".an"},  {4'h0, an},  {4'h0, exp_an});
        check({tag, ".seg"}, {1'b0, seg}, {1'b0, exp_seg});
    endtask

    initial begin
        rst_n    = 1'b0;
        sec_tick = 1'b0;
        {hour1, hour0, min1, min0} = {4'd1, 4'd2, 4'd3, 4'd4};
        repeat (3) @(posedge clk);
        #1;
        check_slot("reset", 4'b1111, 7'h00);
        check("reset.colon", {7'h0, colon}, 8'h0);

        // Release between edges; first frame shows the reset shadow "0".
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        go(1);  check_slot("f0_dead0", 4'b1111, 7'h00);
        go(2);  check_slot("f0_dead1", 4'b1111, 7'h00);
        go(3);  check_slot("f0_s0",    4'b1110, 7'h3F);
        go(11); check_slot("f0_s1",    4'b1101, 7'h3F);
        go(19); check_slot("f0_s2",    4'b1011, 7'h3F);
        go(27); check_slot("f0_s3",    4'b0111, 7'h3F);
        go(32); check_slot("f0_s3end", 4'b0111, 7'h3F);
        go(33); check_slot("f1_dead0", 4'b1111, 7'h00);
        go(34); check_slot("f1_dead1", 4'b1111, 7'h00);

        // Second frame onward shows 12:34.
        go(35); check_slot("f1_s0",    4'b1110, 7'h66);
        go(43); check_slot("f1_s1",    4'b1101, 7'h4F);
        go(51); check_slot("f1_s2",    4'b1011, 7'h5B);
        go(59); check_slot("f1_s3",    4'b0111, 7'h06);
        go(64); check_slot("f1_s3end", 4'b0111, 7'h06);
        go(65); check_slot("f2_dead0", 4'b1111, 7'h00);

        // 12:34 -> 12:35 while slot 1 of frame 2 is lit: no tearing.
        go(67); check_slot("f2_s0",    4'b1110, 7'h66);
        go(75); check_slot("f2_s1",    4'b1101, 7'h4F);
        min0 = 4'd5;
        go(83); check_slot("f2_s2",    4'b1011, 7'h5B);
        go(91); check_slot("f2_s3",    4'b0111, 7'h06);
        go(99); check_slot("f3_s0",    4'b1110, 7'h6D);

        // Non-BCD minute units shows a dash from the next frame.
        min0 = 4'hC;

        // Colon: three ticks 20 cycles apart, each seen one edge later.
        go(100);
        sec_tick = 1'b1;
        check("tick1.before", {7'h0, colon}, 8'h0);
        go(101);
        sec_tick = 1'b0;
        check("tick1.after", {7'h0, colon}, 8'h1);
        go(110); check("colon.hold", {7'h0, colon}, 8'h1);
        go(120);
        sec_tick = 1'b1;
        check("tick2.before", {7'h0, colon}, 8'h1);
        go(121);
        sec_tick = 1'b0;
        check("tick2.after", {7'h0, colon}, 8'h0);

        go(131); check_slot("f4_dash", 4'b1110, 7'h40);

        go(140);
        sec_tick = 1'b1;
        check("tick3.before", {7'h0, colon}, 8'h0);
        go(141);
        sec_tick = 1'b0;
        check("tick3.after", {7'h0, colon}, 8'h1);

        // After edge 181 the scanner sits at idx 2, cnt 5; reset there.
        go(181); check_slot("pre_rst_s2", 4'b1011, 7'h5B);
        rst_n = 1'b0;
        #1;
        check_slot("midscan_rst", 4'b1111, 7'h00);
        check("midscan_rst.colon", {7'h0, colon}, 8'h0);
        {hour1, hour0, min1, min0} = {4'd0, 4'd9, 4'd0, 4'd0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        go(1);  check_slot("r2_dead0", 4'b1111, 7'h00);
        check("r2.colon", {7'h0, colon}, 8'h0);
        go(3);  check_slot("r2_s0",    4'b1110, 7'h3F);
        go(11); check_slot("r2_s1",    4'b1101, 7'h3F);

        // 09:00 in frame 1: hour tens blanked only with SEG7_LZB_EN.
        go(35); check_slot("lz_s0", 4'b1110, 7'h3F);
        go(51); check_slot("lz_s2", 4'b1011, 7'h6F);
        for (int t = 57; t <= 64; t++) begin
            go(t);
`ifdef SEG7_LZB_EN
            check_slot("lz_s3", 4'b1111, 7'h00);
`else
            if (t <= 58) check_slot("lz_s3", 4'b1111, 7'h00);
            else         check_slot("lz_s3", 4'b0111, 7'h3F);
`endif
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
